// File: rtl/song_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : song_pkg                                                     |
// | Description : Shared definitions for the song generator control path:    |
// |               pitch codes, sequencer state encoding and default sizing.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package song_pkg;

    // Default sizing for the sequencer and its note RAM.
    localparam int DEFAULT_NOTE_W         = 4;
    localparam int DEFAULT_SONG_LEN       = 256;
    localparam int DEFAULT_ADDR_W         = 8;
    localparam int DEFAULT_TICKS_PER_BEAT = 12500000;
    localparam int DEFAULT_TICK_W         = 24;

    // Pitch codes: 0 is silence, 1..15 are a chromatic run from D2 to E3.
    typedef enum logic [3:0] {
        REST = 4'd0,
        D2   = 4'd1,
        DS2  = 4'd2,
        E2   = 4'd3,
        F2   = 4'd4,
        FS2  = 4'd5,
        G2   = 4'd6,
        GS2  = 4'd7,
        A2   = 4'd8,
        AS2  = 4'd9,
        B2   = 4'd10,
        C3   = 4'd11,
        CS3  = 4'd12,
        D3   = 4'd13,
        DS3  = 4'd14,
        E3   = 4'd15
    } pitch_e;

    // One-hot sequencer state encoding.
    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 5'b00001,
        ST_GENERATE = 5'b00010,
        ST_PREFETCH = 5'b00100,
        ST_PLAY     = 5'b01000,
        ST_DONE     = 5'b10000
    } state_e;

    // States in which the sequencer reports itself busy.
    function automatic logic state_is_busy(input state_e s);
        return (s == ST_GENERATE) || (s == ST_PREFETCH) || (s == ST_PLAY);
    endfunction

endpackage

`default_nettype wire

// File: rtl/beat_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : beat_timer                                                   |
// | Description : Free-running beat counter with synchronous clear and count  |
// |               enable. Counts 0..TICKS-1 and wraps; o_tc is high while the  |
// |               count sits on its last value.                                |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Ports       : clk   - clock (posedge)                                      |
// |               rst   - synchronous active-high reset                        |
// |               i_clr - synchronous clear to 0 (wins over i_en)              |
// |               i_en  - advance the count this cycle                         |
// |               o_tc  - terminal count (count == TICKS-1)                    |
// +----------------------------------------------------------------------------+

module beat_timer #(
    parameter int TICKS = 3,
    parameter int CNT_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_tc = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : song_sequencer                                               |
// | Description : Top-level controller for the song generator. Accepts one    |
// |               song of SONG_LEN notes from the generator, writes it into   |
// |               the note RAM, then plays it back holding each note for      |
// |               TICKS_PER_BEAT clock cycles.                                 |
// | Revision    : 1.0 - initial release                                        |
// |                                                                            |
// | Build option: SONG_SEQUENCER_LOOP_EN - when defined, playback wraps from  |
// |               the last note back to the first forever and DONE is never   |
// |               entered from PLAY.                                           |
// |                                                                            |
// | Ports       : CLOCK_50  - system clock (posedge)                           |
// |               reset     - synchronous active-high reset                    |
// |               start     - begin a new song (IDLE/DONE only)                |
// |               stop_req  - abort to IDLE from any state                     |
// |               gen_valid / gen_note / gen_ready - generator handshake       |
// |               mem_we / mem_addr / mem_wdata / mem_rdata - note RAM port    |
// |               play_note - pitch currently sounding                         |
// |               note_on   - PLAY and play_note != REST                       |
// |               busy      - GENERATE, PREFETCH or PLAY                       |
// |               done      - DONE                                             |
// +----------------------------------------------------------------------------+

module song_sequencer
    import song_pkg::*;
#(
    parameter int NOTE_W         = DEFAULT_NOTE_W,
    parameter int SONG_LEN       = DEFAULT_SONG_LEN,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int TICKS_PER_BEAT = DEFAULT_TICKS_PER_BEAT,
    parameter int TICK_W         = DEFAULT_TICK_W
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop_req,
    input  logic              gen_valid,
    input  logic [NOTE_W-1:0] gen_note,
    output logic              gen_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [NOTE_W-1:0] mem_wdata,
    input  logic [NOTE_W-1:0] mem_rdata,
    output logic [NOTE_W-1:0] play_note,
    output logic              note_on,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(SONG_LEN - 1);
    localparam logic [NOTE_W-1:0] c_rest      = NOTE_W'(REST);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_e            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_pf_phase;
    logic [NOTE_W-1:0] r_play_note;
    logic              r_note_on;
    logic              r_busy;
    logic              r_done;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic              w_pf_phase_nxt;
    logic [NOTE_W-1:0] w_play_note_nxt;
    logic              w_handshake;
    logic              w_beat_tc;

    assign w_handshake = gen_valid && (r_state == ST_GENERATE);

    // Beat counter runs only while playing; it is held at 0 everywhere else
    // so every PLAY entry starts a fresh beat.
    beat_timer #(
        .TICKS (TICKS_PER_BEAT),
        .CNT_W (TICK_W)
    ) u_beat_timer (
        .clk   (CLOCK_50),
        .rst   (reset),
        .i_clr ((r_state != ST_PLAY) || stop_req),
        .i_en  (r_state == ST_PLAY),
        .o_tc  (w_beat_tc)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pf_phase  <= 1'b0;
            r_play_note <= c_rest;
            r_note_on   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_pf_phase  <= w_pf_phase_nxt;
            r_play_note <= w_play_note_nxt;
            // Status flags are registered from the next state so they line
            // up exactly with the state they describe.
            r_note_on   <= (w_state_nxt == ST_PLAY) && (w_play_note_nxt != c_rest);
            r_busy      <= state_is_busy(w_state_nxt);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_pf_phase_nxt  = r_pf_phase;
        w_play_note_nxt = r_play_note;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt  = ST_GENERATE;
                    w_wr_ptr_nxt = '0;
                end
            end

            ST_GENERATE: begin
                if (w_handshake) begin
                    if (r_wr_ptr == c_last_addr) begin
                        // Explicit wrap: SONG_LEN may be smaller than the
                        // address space.
                        w_wr_ptr_nxt   = '0;
                        w_pf_phase_nxt = 1'b0;
                        w_state_nxt    = ST_PREFETCH;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
                    end
                end
            end

            ST_PREFETCH: begin
                // Address 0 is presented for two cycles; by the second the
                // RAM's one-cycle read latency has delivered note 0.
                if (!r_pf_phase) begin
                    w_pf_phase_nxt = 1'b1;
                end else begin
                    w_pf_phase_nxt  = 1'b0;
                    w_play_note_nxt = mem_rdata;
                    w_rd_ptr_nxt    = '0;
                    w_state_nxt     = ST_PLAY;
                end
            end

            ST_PLAY: begin
                // mem_addr already points one note ahead, so mem_rdata holds
                // the next note by the time the beat expires.
                if (w_beat_tc) begin
                    if (r_rd_ptr != c_last_addr) begin
                        w_play_note_nxt = mem_rdata;
                        w_rd_ptr_nxt    = r_rd_ptr + ADDR_W'(1);
                    end else begin
`ifdef SONG_SEQUENCER_LOOP_EN
                        w_play_note_nxt = mem_rdata;
                        w_rd_ptr_nxt    = '0;
`else
                        w_play_note_nxt = c_rest;
                        w_rd_ptr_nxt    = '0;
                        w_state_nxt     = ST_DONE;
`endif
                    end
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_wr_ptr_nxt    = '0;
                w_rd_ptr_nxt    = '0;
                w_pf_phase_nxt  = 1'b0;
                w_play_note_nxt = c_rest;
            end
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (stop_req) begin
            w_state_nxt     = ST_IDLE;
            w_wr_ptr_nxt    = '0;
            w_rd_ptr_nxt    = '0;
            w_pf_phase_nxt  = 1'b0;
            w_play_note_nxt = c_rest;
        end
    end

    // ------------------------------------------------------------------------
    // Memory-side decode
    // ------------------------------------------------------------------------
    always_comb begin
        mem_addr = '0;
        case (r_state)
            ST_GENERATE: mem_addr = r_wr_ptr;
            ST_PLAY:     mem_addr = r_rd_ptr + ADDR_W'(1);
            default:     mem_addr = '0;
        endcase
    end

    assign gen_ready = (r_state == ST_GENERATE);
    assign mem_we    = w_handshake;
    assign mem_wdata = gen_note;

    assign play_note = r_play_note;
    assign note_on   = r_note_on;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire
